// File: rtl/tdc_display.sv
// ---------------------------------------------------------------------------
// tdc_display
// Time-to-digital converter with a six-digit 7-segment readout. A rising
// edge on sent_signal starts counting clk cycles; a rising edge on
// recieved_signal latches the count into the result register. The result is
// shown in decimal on six active-low 7-segment digits, clamped to 999999.
//
// Ports
//   clk             in   1   sole clock, rising edge
//   rst             in   1   synchronous, active-high reset
//   sent_signal     in   1   start pulse (asynchronous to clk)
//   recieved_signal in   1   stop pulse (asynchronous to clk)
//   busy            out  1   high while a measurement is in progress
//   seg             out  42  digit i at seg[7i+6:7i], bit 7i = a, 7i+6 = g
// ---------------------------------------------------------------------------
module tdc_display #(
    parameter int PERIODS_DIM = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sent_signal,
    input  logic        recieved_signal,
    output logic        busy,
    output logic [41:0] seg
);

    localparam logic [PERIODS_DIM-1:0] CNT_MAX  = '1;
    localparam logic [19:0]            DISP_MAX = 20'd999999;
    localparam logic [6:0]             SEG_ZERO = 7'b1000000;

    typedef enum logic {IDLE, COUNT} state_t;

    state_t                 state;
    logic [PERIODS_DIM-1:0] cnt;
    logic [PERIODS_DIM-1:0] result;

    logic sent_sync_p0, sent_sync_p1, sent_dly_p2, sent_arm;
    logic recv_sync_p0, recv_sync_p1, recv_dly_p2, recv_arm;
    logic vld_p0, vld_p1;
    logic sent_p, recv_p;

    logic [23:0] bcd;
    logic [41:0] seg_next;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [PERIODS_DIM-1:0] sat_inc(input logic [PERIODS_DIM-1:0] v);
        if (v == CNT_MAX)
            return CNT_MAX;
        return v + PERIODS_DIM'(1);
    endfunction

    // Clamp to the largest value six decimal digits can show.
    function automatic logic [19:0] sat_disp(input logic [PERIODS_DIM-1:0] v);
        if (v > {{(PERIODS_DIM-20){1'b0}}, DISP_MAX})
            return DISP_MAX;
        return v[19:0];
    endfunction

    // Double-dabble: 20-bit binary (<= 999999) to six BCD digits.
    function automatic logic [23:0] bin2bcd(input logic [19:0] bin);
        logic [43:0] sh;
        sh = {24'd0, bin};
        for (int i = 0; i < 20; i++) begin
            for (int d = 0; d < 6; d++) begin
                if (sh[20+4*d +: 4] >= 4'd5)
                    sh[20+4*d +: 4] = sh[20+4*d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
        return sh[43:20];
    endfunction

    // Hex digit to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // --- Stage p0/p1: two-flop synchronizers, p2: edge-detect delay flop ---
    // vld_p1 marks when the synchronizer holds real input samples rather than
    // reset values. An edge is only armed once the synchronized input has been
    // seen low with valid data, so a level held high through reset release
    // never looks like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_sync_p0 <= 1'b0;
            sent_sync_p1 <= 1'b0;
            sent_dly_p2  <= 1'b0;
            sent_arm     <= 1'b0;
            recv_sync_p0 <= 1'b0;
            recv_sync_p1 <= 1'b0;
            recv_dly_p2  <= 1'b0;
            recv_arm     <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
        end else begin
            sent_sync_p0 <= sent_signal;
            sent_sync_p1 <= sent_sync_p0;
            sent_dly_p2  <= sent_sync_p1;
            recv_sync_p0 <= recieved_signal;
            recv_sync_p1 <= recv_sync_p0;
            recv_dly_p2  <= recv_sync_p1;
            vld_p0       <= 1'b1;
            vld_p1       <= vld_p0;
            if (vld_p1 && !sent_sync_p1)
                sent_arm <= 1'b1;
            if (vld_p1 && !recv_sync_p1)
                recv_arm <= 1'b1;
        end
    end

    assign sent_p = sent_sync_p1 & ~sent_dly_p2 & sent_arm;
    assign recv_p = recv_sync_p1 & ~recv_dly_p2 & recv_arm;

    // --- Measurement FSM ---
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A simultaneous stop is ignored: nothing was being timed.
                    if (sent_p) begin
                        cnt   <= PERIODS_DIM'(1);
                        state <= COUNT;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (recv_p)
                        result <= cnt;
                    if (sent_p) begin
                        cnt <= PERIODS_DIM'(1);
                    end else if (recv_p) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // --- Display: clamp, BCD convert, decode, register ---
    assign bcd = bin2bcd(sat_disp(result));

    always_comb begin
        seg_next = '0;
        for (int i = 0; i < 6; i++)
            seg_next[7*i +: 7] = hex7(bcd[4*i +: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            seg <= {6{SEG_ZERO}};
        else
            seg <= seg_next;
    end

endmodule

// File: tb/tb_tdc_display.sv
module tb_tdc_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sent = 1'b0;
    logic        recv = 1'b0;
    logic        busy;
    logic [41:0] seg;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    tdc_display #(.PERIODS_DIM(24)) dut (
        .clk             (clk),
        .rst             (rst),
        .sent_signal     (sent),
        .recieved_signal (recv),
        .busy            (busy),
        .seg             (seg)
    );

    always #5 clk = ~clk;

    // Busy cycle counter, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (busy === 1'b1)
            busy_cnt = busy_cnt + 1;
    end

    typedef struct {
        int unsigned delay;
        int unsigned disp;
    } vec_t;

    function automatic logic [6:0] pat(input int unsigned d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [41:0] exp_seg(input int unsigned value);
        logic [41:0] s;
        int unsigned v;
        v = (value > 999999) ? 999999 : value;
        s = '0;
        for (int i = 0; i < 6; i++) begin
            s[7*i +: 7] = pat(v % 10);
            v = v / 10;
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start edge, stop edge n cycles later, then let the display settle.
    task automatic measure(input int n);
        @(negedge clk);
        busy_cnt = 0;
        sent = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1)
                sent = 1'b0;
        end
        recv = 1'b1;
        @(negedge clk);
        recv = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Start a measurement, jump the counter to v mid-count, then stop.
    // The stop edge is sampled two edges later, so result = v + 2 (saturating).
    task automatic force_measure(input logic [23:0] v, input int unsigned disp, input string name);
        @(negedge clk);
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        repeat (3) @(negedge clk);
        force dut.cnt = v;
        recv = 1'b1;
        #1;
        release dut.cnt;
        @(negedge clk);
        recv = 1'b0;
        repeat (4) @(negedge clk);
        check(name, seg, exp_seg(disp));
        check({name, "_busy"}, {41'd0, busy}, 42'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{delay: 100,   disp: 100};
        vecs[1] = '{delay: 9,     disp: 9};
        vecs[2] = '{delay: 1,     disp: 1};
        vecs[3] = '{delay: 2,     disp: 2};
        vecs[4] = '{delay: 12345, disp: 12345};
        vecs[5] = '{delay: 999,   disp: 999};

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_seg", seg, exp_seg(0));
        check("reset_busy", {41'd0, busy}, 42'd0);
        repeat (5) @(negedge clk);

        // Table of plain measurements
        foreach (vecs[k]) begin
            measure(int'(vecs[k].delay));
            check($sformatf("meas_%0d_seg", vecs[k].delay), seg, exp_seg(vecs[k].disp));
            check($sformatf("meas_%0d_busy", vecs[k].delay), {41'd0, busy}, 42'd0);
            check($sformatf("meas_%0d_busycycles", vecs[k].delay), 42'(busy_cnt), 42'(vecs[k].delay));
        end

        // Stop edge with no start: nothing changes
        @(negedge clk);
        busy_cnt = 0;
        recv = 1'b1;
        @(negedge clk);
        recv = 1'b0;
        repeat (6) @(negedge clk);
        check("lone_recv_seg", seg, exp_seg(999));
        check("lone_recv_busycycles", 42'(busy_cnt), 42'd0);

        // Second start 50 cycles in, stop 30 cycles after that
        @(negedge clk);
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        repeat (49) @(negedge clk);
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        repeat (29) @(negedge clk);
        recv = 1'b1;
        @(negedge clk);
        recv = 1'b0;
        repeat (4) @(negedge clk);
        check("restart_seg", seg, exp_seg(30));
        check("restart_busy", {41'd0, busy}, 42'd0);

        // Start and stop together while counting: latch 20, keep counting
        @(negedge clk);
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        repeat (19) @(negedge clk);
        sent = 1'b1;
        recv = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        recv = 1'b0;
        repeat (4) @(negedge clk);
        check("both_count_seg", seg, exp_seg(20));
        check("both_count_busy", {41'd0, busy}, 42'd1);
        recv = 1'b1;  // 5 cycles after the restart edge
        @(negedge clk);
        recv = 1'b0;
        repeat (4) @(negedge clk);
        check("after_restart_seg", seg, exp_seg(5));
        check("after_restart_busy", {41'd0, busy}, 42'd0);

        // Start and stop together while idle: start only
        @(negedge clk);
        sent = 1'b1;
        recv = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        recv = 1'b0;
        repeat (4) @(negedge clk);
        check("both_idle_busy", {41'd0, busy}, 42'd1);
        check("both_idle_seg", seg, exp_seg(5));

        // Reset mid-count
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", {41'd0, busy}, 42'd0);
        check("rst_mid_seg", seg, exp_seg(0));
        repeat (5) @(negedge clk);
        check("rst_mid_seg_hold", seg, exp_seg(0));

        // Start held high through reset release must not start a measurement
        rst = 1'b1;
        sent = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        busy_cnt = 0;
        repeat (8) @(negedge clk);
        check("held_sent_busycycles", 42'(busy_cnt), 42'd0);
        sent = 1'b0;
        repeat (3) @(negedge clk);
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        repeat (3) @(negedge clk);
        check("new_edge_busy", {41'd0, busy}, 42'd1);
        recv = 1'b1;  // 4 cycles after the start edge
        @(negedge clk);
        recv = 1'b0;
        repeat (4) @(negedge clk);
        check("new_edge_seg", seg, exp_seg(4));

        // Long delays reached by jumping the counter
        force_measure(24'd1234565, 999999, "delay_1234567");
        force_measure(24'd999997,  999999, "delay_999999");
        force_measure(24'd999998,  999999, "delay_1000000");
        force_measure(24'd123454,  123456, "delay_123456");
        force_measure(24'hFFFFFE,  999999, "delay_saturate");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_display.md
TDC_DISPLAY -- requirements
Module: tdc_display

Interface
REQ-001 Parameter PERIODS_DIM, default 24, sets the width of the delay counter and result register; only the value 24 is supported.
REQ-002 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 sent_signal  input  1  start pulse, asynchronous to clk; its rising edge starts a measurement.
REQ-005 recieved_signal  input  1  stop pulse, asynchronous to clk; its rising edge ends a measurement.
REQ-006 busy  output  1  high while a measurement is in progress.
REQ-007 seg  output  42  six 7-segment digits; digit i (i=0 is least significant) occupies seg[7i+6:7i], with a at bit 7i and g at bit 7i+6, active-low.

Function
REQ-008 Each input SHALL pass through a 2-flop synchronizer followed by a rising-edge detector that produces a one-cycle pulse (sent_p, recv_p); both paths SHALL have identical latency.
REQ-009 The FSM SHALL have two states, IDLE and COUNT; busy=1 exactly in COUNT.
REQ-010 IDLE: on sent_p, cnt<=1 and go to COUNT; recv_p alone SHALL be ignored.
REQ-011 COUNT: each cycle without recv_p, cnt<=cnt+1, saturating at 2^PERIODS_DIM-1 (no wrap).
REQ-012 COUNT with recv_p: result<=cnt and go to IDLE; result therefore equals N when recv_p occurs N cycles after sent_p.
REQ-013 COUNT with sent_p and no recv_p: restart, cnt<=1, stay in COUNT; the earlier start is discarded.
REQ-014 COUNT with sent_p and recv_p in the same cycle: result<=cnt, then restart with cnt<=1 and stay in COUNT.
REQ-015 IDLE with sent_p and recv_p in the same cycle: start only (cnt<=1, go to COUNT).
REQ-016 result SHALL hold its value until the next completed measurement.
REQ-017 Binary-to-BCD conversion (combinational, e.g. double-dabble) SHALL produce 6 BCD digits of result; any result greater than 999999 SHALL be displayed as 999999.
REQ-018 Each BCD digit SHALL drive a 16-entry hex-to-7-segment decoder.
REQ-019 Decoder patterns {g,f,e,d,c,b,a}, active-low: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-020 seg SHALL be registered; seg reflects a new result one clk after result updates.
REQ-021 Leading zeros SHALL be displayed (no blanking).

Reset
REQ-022 With rst=1 at a clk edge: state<=IDLE, cnt<=0, result<=0, busy<=0, synchronizer and edge-detect flops<=0, seg<=six copies of 1000000 (display "000000").
REQ-023 Reset asserted during COUNT SHALL abort the measurement and leave result=0.
REQ-024 A sent_signal held high through reset release SHALL NOT produce sent_p; a new rising edge is required.

Verification
REQ-025 rst 1 for 2 cycles, then release -> seg shows 000000, busy=0.
REQ-026 Sent rising edge, then recieved rising edge 100 clks later -> result=100, seg digit0=1000000, digit1=1000000, digit2=1111001, upper digits 0; busy high for 100 cycles.
REQ-027 Recieved rising edge with no prior sent edge -> result and seg unchanged, busy stays 0.
REQ-028 Sent edge, second sent edge 50 clks later, recieved edge 30 clks after that -> result=30.
REQ-029 Recieved edge 1,234,567 clks after sent edge -> display 999999; delay 999,999 -> display 999999; delay 9 -> display 000009.
REQ-030 Sent and recieved edges in the same cycle while IDLE -> measurement starts, busy=1, result unchanged; rst asserted mid-count -> busy=0, display 000000.
